button_press_classifier: RTL and testbench
==========================================

# button_press_classifier

Classifies the clean, debounced button level from `button_conditioner` into discrete one-cycle events: press, short press, long press and double press. It sits directly downstream of `button_conditioner`, whose `out` drives `btn_in`. Its pulses feed control/UI logic in the same clock domain. All timing is counted in `clk` cycles.

## Interface
- `LONG_COUNT`, default 1000: consecutive high samples that qualify a long press; must be ≥2.
- `DCLICK_GAP`, default 250: consecutive low samples after a short press before it is declared single; must be ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_in`  in  1  debounced level, synchronous to `clk`.
- `press_pulse`  out  1  one-cycle pulse on every accepted rising edge.
- `short_press`  out  1  one-cycle pulse: short press not followed by a second press.
- `long_press`  out  1  one-cycle pulse: hold reached `LONG_COUNT`.
- `double_press`  out  1  one-cycle pulse on the rising edge of the second press.
- `held`  out  1  level: high while the FSM is in PRESSED, LONG_HELD or SECOND.

## Operation
- Edge detect: `btn_q` holds the previous `btn_in`. Rise = `btn_in & ~btn_q`. Fall = `~btn_in & btn_q`.
- Counter `cnt` is unsigned, width `$clog2(max(LONG_COUNT, DCLICK_GAP))+1`, and never wraps.
- FSM:
  - IDLE: on rise, go to PRESSED, set `cnt=1`, pulse `press_pulse`.
  - PRESSED, `btn_in=1`: if `cnt==LONG_COUNT-1`, pulse `long_press` and go to LONG_HELD; otherwise `cnt++`.
  - PRESSED, `btn_in=0`: go to GAP, set `cnt=1`.
  - LONG_HELD: stay while `btn_in=1`. On `btn_in=0`, go to IDLE with no `short_press`.
  - GAP, `btn_in=1` (rise): pulse `press_pulse` and `double_press`, go to SECOND.
  - GAP, `btn_in=0`: if `cnt==DCLICK_GAP-1`, pulse `short_press` and go to IDLE; otherwise `cnt++`.
  - SECOND: stay while `btn_in=1`; no long detection in this state. On `btn_in=0`, go to IDLE.
- Simultaneous events:
  - In GAP, a rise on the same edge that `cnt` would expire: the rise wins and `double_press` fires, not `short_press`.
  - At most one event pulse besides `press_pulse` is high in any cycle.
- Reset:
  - Asynchronous, mid-operation included. Forces IDLE, `cnt=0`, and all outputs to 0.
  - `btn_q` resets to 1, so a button already held at reset release is not a press. It must be released and pressed again.

## Timing
- All outputs are registered. Every output is 0 during reset.
- `press_pulse` and `double_press`: high for the one cycle following the clock edge that samples the rise.
- `long_press`: high for the one cycle following the edge of the `LONG_COUNT`-th consecutive high sample, counting the rising-edge sample.
- `short_press`: high for the one cycle following the edge of the `DCLICK_GAP`-th consecutive low sample after release.
- `held`: rises one cycle after the rise is sampled and falls one cycle after the fall is sampled.
- `btn_in` is debounced upstream, so no minimum pulse width is imposed. A 1-cycle high in IDLE gives `press_pulse`, then GAP, then `short_press`.

## Structure
- Package `btn_pkg`:
  - `typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND} press_state_t`.
  - Function `cnt_width(long, gap)` returning the counter width.
- Sub-module `btn_edge_detect` (clk, reset, in, rise, fall, with the `btn_q` reset value as a parameter). The FSM and counter stay in the top module.

## Test plan
All scenarios use `LONG_COUNT=8`, `DCLICK_GAP=4`.
- Hold high 3 cycles, release, stay low 6 cycles: `press_pulse` once, `short_press` once, on the 4th low sample. No `long_press` or `double_press`.
- Hold high 12 cycles: `long_press` once, after the 8th high sample. `held` stays high 12 cycles. No `short_press` on release.
- High 2, low 2, high 2, low 6: two `press_pulse`, one `double_press` on the second rise. No `short_press`.
- High 2, then low exactly 3 cycles so the 4th sample would expire, with the rise on that 4th edge: `double_press`, not `short_press`.
- Pull `reset` low while in PRESSED with `cnt=5`: all outputs drop to 0 immediately. After release, the still-held button produces no `press_pulse`; the next full release-and-press produces one.
- `btn_in` high 1 cycle from IDLE: `press_pulse`, then `short_press` after 4 low samples, and `held` high for exactly 1 cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button press classifier.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    GAP,
    SECOND
  } press_state_t;

  // The counter holds values up to max(long, gap) - 1.
  // One spare bit keeps the width comfortable for small parameter values.
  function automatic int cnt_width(input int long_cnt, input int gap_cnt);
    int m;
    m = (long_cnt > gap_cnt) ? long_cnt : gap_cnt;
    return $clog2(m) + 1;
  endfunction

  // States in which the button is considered physically down.
  function automatic logic is_held(input press_state_t s);
    return (s == PRESSED) || (s == LONG_HELD) || (s == SECOND);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the previous button level and derives rise/fall strobes.
// The reset value of the history bit is a parameter. Resetting it high means
// a button already held when reset is released does not read as a rise.
module btn_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // Previous-sample history bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= RST_VAL;
    else        btn_q <= in;
  end

  assign rise = in & ~btn_q;
  assign fall = ~in & btn_q;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into one-cycle press / short / long / double
// events plus a registered "held" level. All outputs are registered.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_COUNT = 1000,
  parameter int DCLICK_GAP = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  localparam int              CW        = cnt_width(LONG_COUNT, DCLICK_GAP);
  localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_COUNT - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(DCLICK_GAP - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  press_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rise, fall;
  logic          press_nxt, short_nxt, long_nxt, double_nxt, held_nxt;

  btn_edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (btn_in),
    .rise  (rise),
    .fall  (fall)
  );

  // State, counter and registered event outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      press_pulse  <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      press_pulse  <= press_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      held         <= held_nxt;
    end
  end

  // Next-state, counter and event decode. The counter saturates at the
  // terminal value of each timing window, so it never wraps. In GAP a new
  // press is tested before the gap timer, so a rise on the expiry edge
  // becomes a double press rather than a short press.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ONE;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (!btn_in) state_nxt = IDLE;
      end
      GAP: begin
        if (rise) begin
          state_nxt  = SECOND;
          press_nxt  = 1'b1;
          double_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      SECOND: begin
        if (!btn_in) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    held_nxt = is_held(state_nxt);
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_COUNT=8, DCLICK_GAP=4.
// Each step drives one btn_in sample and checks the registered outputs
// {press_pulse, short_press, long_press, double_press, held} after that edge.
module tb_button_press_classifier;

  logic clk;
  logic reset;
  logic btn_in;
  logic press_pulse, short_press, long_press, double_press, held;

  int checks = 0;
  int errors = 0;

  button_press_classifier #(
    .LONG_COUNT (8),
    .DCLICK_GAP (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector order: {press, short, long, double, held}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {press_pulse, short_press, long_press, double_press, held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge, then check just after the rising edge.
  task automatic cyc(input logic b, input logic [4:0] exp, input string tag);
    @(negedge clk);
    btn_in = b;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 1'b0;
    #2;
    chk("reset_async", 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 5'b00000, "idle0");
    cyc(0, 5'b00000, "idle1");

    // Short press: high 3, low 6; short on the 4th low sample.
    cyc(1, 5'b10001, "s1_rise");
    cyc(1, 5'b00001, "s1_h2");
    cyc(1, 5'b00001, "s1_h3");
    cyc(0, 5'b00000, "s1_l1");
    cyc(0, 5'b00000, "s1_l2");
    cyc(0, 5'b00000, "s1_l3");
    cyc(0, 5'b01000, "s1_short");
    cyc(0, 5'b00000, "s1_l5");
    cyc(0, 5'b00000, "s1_l6");

    // Long press: high 12; long after the 8th high sample; no short on release.
    cyc(1, 5'b10001, "s2_rise");
    for (int i = 2; i <= 7; i++) cyc(1, 5'b00001, $sformatf("s2_h%0d", i));
    cyc(1, 5'b00101, "s2_long");
    for (int i = 9; i <= 12; i++) cyc(1, 5'b00001, $sformatf("s2_h%0d", i));
    for (int i = 1; i <= 6; i++) cyc(0, 5'b00000, $sformatf("s2_l%0d", i));

    // Double press: high 2, low 2, high 2, low 6.
    cyc(1, 5'b10001, "s3_rise1");
    cyc(1, 5'b00001, "s3_h2");
    cyc(0, 5'b00000, "s3_l1");
    cyc(0, 5'b00000, "s3_l2");
    cyc(1, 5'b10011, "s3_double");
    cyc(1, 5'b00001, "s3_h2b");
    for (int i = 1; i <= 6; i++) cyc(0, 5'b00000, $sformatf("s3_tail%0d", i));

    // Rise on the gap expiry edge wins over short press.
    cyc(1, 5'b10001, "s4_rise1");
    cyc(1, 5'b00001, "s4_h2");
    cyc(0, 5'b00000, "s4_l1");
    cyc(0, 5'b00000, "s4_l2");
    cyc(0, 5'b00000, "s4_l3");
    cyc(1, 5'b10011, "s4_double_at_expiry");
    cyc(0, 5'b00000, "s4_rel");
    for (int i = 1; i <= 5; i++) cyc(0, 5'b00000, $sformatf("s4_tail%0d", i));

    // Asynchronous reset while PRESSED with cnt=5.
    cyc(1, 5'b10001, "s5_rise");
    for (int i = 2; i <= 5; i++) cyc(1, 5'b00001, $sformatf("s5_h%0d", i));
    #2;
    reset = 1'b0;
    #1;
    chk("s5_reset_async", 5'b00000);
    cyc(1, 5'b00000, "s5_in_reset1");
    cyc(1, 5'b00000, "s5_in_reset2");
    @(negedge clk);
    reset = 1'b1;
    btn_in = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_held_no_press0", 5'b00000);
    cyc(1, 5'b00000, "s5_held_no_press1");
    cyc(1, 5'b00000, "s5_held_no_press2");
    cyc(0, 5'b00000, "s5_release");
    cyc(1, 5'b10001, "s5_repress");
    cyc(0, 5'b00000, "s5_l1");
    cyc(0, 5'b00000, "s5_l2");
    cyc(0, 5'b00000, "s5_l3");
    cyc(0, 5'b01000, "s5_short");
    cyc(0, 5'b00000, "s5_idle");

    // Single-cycle press from IDLE.
    cyc(1, 5'b10001, "s6_rise");
    cyc(0, 5'b00000, "s6_l1");
    cyc(0, 5'b00000, "s6_l2");
    cyc(0, 5'b00000, "s6_l3");
    cyc(0, 5'b01000, "s6_short");
    cyc(0, 5'b00000, "s6_idle1");
    cyc(0, 5'b00000, "s6_idle2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
